smd_multipad_encoder: RTL and testbench

- Parametrised N-port Sega Genesis/Mega Drive six-button pad encoder, the successor to the single-port encoder.
- Each channel watches its console SEL line (DB9 pin 7) and drives the six DB9 data pins from that channel's 12 active-low buttons.
- Adds per-channel SEL synchronisation, per-channel timeout/phase tracking, a defined edge-vs-timeout priority, reset-time mode latching and a mode status output.
- Sits between the button-scanning front end and the DB9 output drivers, one instance per board.

---
 rtl/smd_multipad_encoder.sv | 143 ++++++++++++++
 tb/tb_smd_multipad_encoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smd_multipad_encoder.sv
// N-channel Sega Genesis/Mega Drive six-button pad encoder with per-channel SEL sync, phase/timeout tracking and reset-time mode latch.
// Optional macro SMD_AUTOFIRE_EN builds the shared autofire square wave applied to a/b/c on turbo channels.
module smd_multipad_encoder #(
  parameter int NPORTS          = 2,
  parameter int TIMEOUT         = 8000,
  parameter int AUTOFIRE_PERIOD = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORTS-1:0]     p7,
  input  logic [12*NPORTS-1:0]  btn,
  input  logic [NPORTS-1:0]     turbo,
  output logic [6*NPORTS-1:0]   p,
  output logic [NPORTS-1:0]     mode3
);

  localparam logic [15:0] CNT_LOAD = 16'(TIMEOUT);

  logic [NPORTS-1:0]        s1_q, s2_q;
  logic [NPORTS-1:0]        sel_rise;
  logic [NPORTS-1:0]        mode3_q, mode3_d;
  logic                     mode_set_q;
  logic [NPORTS-1:0]        md_vec;
  logic [NPORTS-1:0][1:0]   phase_q, phase_d;
  logic [NPORTS-1:0][15:0]  cnt_q, cnt_d;
  logic [NPORTS-1:0][11:0]  btn_eff;

  function automatic logic [5:0] pad_mux(input logic [1:0] ph, input logic sel,
                                         input logic [11:0] w);
    logic [5:0] o;
    // w = {md,z,y,x,st,c,b,a,rg,lf,dw,up}; o = {pin1,pin2,pin3,pin4,pin6,pin9}
    if (ph == 2'd3)
      o = sel ? {w[10], w[9], w[8], w[11], 2'b11} : {w[11], 3'b111, w[4], w[7]};
    else if (sel)
      o = {w[0], w[1], w[2], w[3], w[5], w[6]};
    else if (ph == 2'd2)
      o = {4'b0000, w[4], w[7]};
    else
      o = {w[0], w[1], 2'b00, w[4], w[7]};
    return o;
  endfunction

`ifdef SMD_AUTOFIRE_EN
  localparam int AFW = (AUTOFIRE_PERIOD > 1) ? $clog2(AUTOFIRE_PERIOD) : 1;
  localparam logic [AFW-1:0] AF_LAST = AFW'(AUTOFIRE_PERIOD - 1);

  logic [AFW-1:0] af_cnt_q, af_cnt_d;
  logic           af_q, af_d;

  always_comb begin
    af_cnt_d = af_cnt_q + AFW'(1);
    af_d     = af_q;
    if (af_cnt_q == AF_LAST) begin
      af_cnt_d = '0;
      af_d     = ~af_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      af_cnt_q <= '0;
      af_q     <= 1'b1;
    end else begin
      af_cnt_q <= af_cnt_d;
      af_q     <= af_d;
    end
  end

  always_comb begin
    btn_eff = '0;
    for (int i = 0; i < NPORTS; i++) begin
      btn_eff[i] = btn[12*i +: 12];
      // While af is low, a/b/c on a turbo channel read as released.
      btn_eff[i][6:4] = btn_eff[i][6:4] | {3{turbo[i] & ~af_q}};
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^turbo ^ AUTOFIRE_PERIOD[0];

  always_comb begin
    btn_eff = '0;
    for (int i = 0; i < NPORTS; i++) btn_eff[i] = btn[12*i +: 12];
  end
`endif

  assign sel_rise = s1_q & ~s2_q;
  assign mode3    = mode3_q;

  always_comb begin
    md_vec = '0;
    for (int i = 0; i < NPORTS; i++) md_vec[i] = btn[12*i + 11];
  end

  // Mode is captured once, on the first edge after reset, and held.
  assign mode3_d = mode_set_q ? mode3_q : ~md_vec;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NPORTS; i++) begin
      if (!mode3_q[i]) begin
        if (sel_rise[i]) begin
          // A SEL edge landing on the timeout cycle still counts as the first edge.
          phase_d[i] = (cnt_q[i] == 16'd0) ? 2'd1 : phase_q[i] + 2'd1;
          cnt_d[i]   = CNT_LOAD;
        end else if (cnt_q[i] == 16'd0) begin
          phase_d[i] = 2'd0;
          cnt_d[i]   = CNT_LOAD;
        end else begin
          cnt_d[i] = cnt_q[i] - 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      mode_set_q <= 1'b0;
      mode3_q    <= '0;
      phase_q    <= '0;
      cnt_q      <= {NPORTS{CNT_LOAD}};
    end else begin
      s1_q       <= p7;
      s2_q       <= s1_q;
      mode_set_q <= 1'b1;
      mode3_q    <= mode3_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
    end
  end

  // Raw p7 feeds the mux so the pins follow SEL with no clock latency.
  always_comb begin
    p = '1;
    for (int i = 0; i < NPORTS; i++) begin
      if (!rst) p[6*i +: 6] = pad_mux(phase_q[i], p7[i], btn_eff[i]);
    end
  end

endmodule

// File: tb/tb_smd_multipad_encoder.sv
// Self-checking bench for smd_multipad_encoder: randomized and directed SEL/button stimulus against a behavioural pad model.
module tb_smd_multipad_encoder;

  localparam int NP  = 2;
  localparam int TO  = 20;
  localparam int AFP = 4;

  logic              clk;
  logic              rst_r;
  logic [NP-1:0]     p7_r;
  logic [12*NP-1:0]  btn_r;
  logic [NP-1:0]     turbo_r;
  logic [6*NP-1:0]   p;
  logic [NP-1:0]     mode3;

  int tests_run = 0;
  int fails     = 0;

  smd_multipad_encoder #(
    .NPORTS(NP), .TIMEOUT(TO), .AUTOFIRE_PERIOD(AFP)
  ) dut (
    .clk(clk), .rst(rst_r), .p7(p7_r), .btn(btn_r), .turbo(turbo_r),
    .p(p), .mode3(mode3)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase is tracked from the time stamp of the last phase event;
  // SEL edges are seen through a two-sample delay of the raw line.
  int   m_n;
  int   m_ph   [NP];
  int   m_last [NP];
  logic m_d1   [NP];
  logic m_d2   [NP];
  logic m_m3   [NP];

  always @(posedge clk) begin
    if (rst_r) begin
      m_n <= 0;
      for (int i = 0; i < NP; i++) begin
        m_ph[i] <= 0; m_last[i] <= 0; m_d1[i] <= 1'b0; m_d2[i] <= 1'b0; m_m3[i] <= 1'b0;
      end
    end else begin
      m_n <= m_n + 1;
      for (int i = 0; i < NP; i++) begin
        if (!m_m3[i]) begin
          if (m_d1[i] && !m_d2[i]) begin
            m_ph[i]   <= ((m_n + 1 - m_last[i]) == TO + 1) ? 1 : (m_ph[i] + 1) % 4;
            m_last[i] <= m_n + 1;
          end else if ((m_n + 1 - m_last[i]) == TO + 1) begin
            m_ph[i]   <= 0;
            m_last[i] <= m_n + 1;
          end
        end
        m_d1[i] <= p7_r[i];
        m_d2[i] <= m_d1[i];
        if (m_n == 0) m_m3[i] <= !btn_r[12*i + 11];
      end
    end
  end

`ifdef SMD_AUTOFIRE_EN
  function automatic logic ref_af();
    return ((m_n / AFP) % 2) == 0;
  endfunction
`endif

  function automatic logic [5:0] ref_pad(input int ch);
    logic md, z, y, x, st, c, b, a, rg, lf, dw, up;
    logic sel;
    {md, z, y, x, st, c, b, a, rg, lf, dw, up} = btn_r[12*ch +: 12];
`ifdef SMD_AUTOFIRE_EN
    if (turbo_r[ch] && !ref_af()) begin a = 1'b1; b = 1'b1; c = 1'b1; end
`endif
    sel = p7_r[ch];
    if (rst_r) return 6'h3f;
    case (m_ph[ch])
      3:       return sel ? {z, y, x, md, 2'b11} : {md, 3'b111, a, st};
      2:       return sel ? {up, dw, lf, rg, b, c} : {4'b0000, a, st};
      default: return sel ? {up, dw, lf, rg, b, c} : {up, dw, 2'b00, a, st};
    endcase
  endfunction

  function automatic logic [6*NP-1:0] ref_p();
    logic [6*NP-1:0] r;
    for (int ch = 0; ch < NP; ch++) r[6*ch +: 6] = ref_pad(ch);
    return r;
  endfunction

  function automatic logic [NP-1:0] ref_mode3();
    logic [NP-1:0] r;
    for (int ch = 0; ch < NP; ch++) r[ch] = m_m3[ch];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic [NP-1:0] s,
                      input logic [12*NP-1:0] b, input logic [NP-1:0] t);
    @(negedge clk);
    rst_r = r; p7_r = s; btn_r = b; turbo_r = t;
    #1;
  endtask

  task automatic do_reset(input logic [12*NP-1:0] b);
    for (int k = 0; k < 3; k++) step(1'b1, '0, b, '0);
    step(1'b0, '0, b, '0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, NP'($urandom), (12*NP)'($urandom), NP'($urandom));
      tests_run++;
      if (p !== '1) begin
        fails++; $display("FAIL reset_p got=%h exp=%h", p, {(6*NP){1'b1}});
      end
      tests_run++;
      if (mode3 !== '0) begin
        fails++; $display("FAIL reset_mode3 got=%b exp=%b", mode3, {NP{1'b0}});
      end
    end
    step(1'b0, '0, '1, '0);
    step(1'b0, '0, '1, '0);
    tests_run++;
    if (p !== {NP{6'b110011}}) begin
      fails++; $display("FAIL release_p got=%h exp=%h", p, {NP{6'b110011}});
    end
    tests_run++;
    if (mode3 !== '0) begin
      fails++; $display("FAIL release_mode3 got=%b exp=00", mode3);
    end
  endtask

  task automatic test_six_button();
    logic [12*NP-1:0] b;
    b = '1;
    b[10] = 1'b0;  // channel 0 z pressed
    do_reset(b);
    for (int k = 0; k < 3; k++) step(1'b0, '0, b, '0);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 6; j++) begin
        step(1'b0, {1'b0, (j < 3)}, b, '0);
        tests_run++;
        if (p !== ref_p()) begin
          fails++; $display("FAIL six_button k=%0d j=%0d got=%h exp=%h", k, j, p, ref_p());
        end
        if (k == 1 && j >= 3) begin
          tests_run++;
          if (p[5:0] !== 6'b000011) begin
            fails++; $display("FAIL six_id j=%0d got=%b exp=000011", j, p[5:0]);
          end
        end
        if (k == 2 && j == 2) begin
          tests_run++;
          if (p[5:0] !== 6'b011111) begin
            fails++; $display("FAIL phase3_high got=%b exp=011111", p[5:0]);
          end
        end
        if (k == 3 && j == 2) begin
          tests_run++;
          if (p[5:0] !== 6'b111111) begin
            fails++; $display("FAIL phase_wrap got=%b exp=111111", p[5:0]);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [12*NP-1:0] b;
    int gap;
    for (int r = 0; r < 3; r++) begin
      b = (12*NP)'($urandom) | {1'b1, 11'h0, 1'b1, 11'h0};
      do_reset(b);
      gap = (r == 0) ? TO + 1 : $urandom_range(TO - 4, TO + 8);
      for (int s = 0; s < gap + 3 + 20; s++) begin
        step(1'b0, {1'b0, (s < 3) || (s >= gap + 3 && s < gap + 6) ||
                           (s >= gap + 9 && s < gap + 12)}, b, '0);
        tests_run++;
        if (p !== ref_p()) begin
          fails++; $display("FAIL timeout gap=%0d s=%0d got=%h exp=%h", gap, s, p, ref_p());
        end
      end
    end
  endtask

  task automatic test_coincident();
    int sp;
    for (int v = 0; v < 3; v++) begin
      sp = TO + v;
      do_reset('1);
      step(1'b0, '0, '1, '0);
      for (int s = 0; s < sp + 16; s++) begin
        step(1'b0, {1'b0, (s < 3) || (s >= sp && s < sp + 3) || (s >= sp + 6 && s < sp + 9)},
             '1, '0);
        tests_run++;
        if (p !== ref_p()) begin
          fails++; $display("FAIL coincident sp=%0d s=%0d got=%h exp=%h", sp, s, p, ref_p());
        end
        if (s >= sp + 10 && s < sp + 13) begin
          tests_run++;
          if (p[5:0] !== ((sp == TO) ? 6'b111111 : 6'b000011)) begin
            fails++; $display("FAIL coincident_phase sp=%0d got=%b exp=%b", sp, p[5:0],
                              (sp == TO) ? 6'b111111 : 6'b000011);
          end
        end
      end
    end
  endtask

  task automatic test_mode3();
    logic [12*NP-1:0] b;
    logic [5:0]       e1;
    b = '1;
    b[23] = 1'b0;  // channel 1 md held low through release
    do_reset(b);
    step(1'b0, '0, b, '0);
    tests_run++;
    if (mode3 !== 2'b10) begin
      fails++; $display("FAIL mode3_latch got=%b exp=10", mode3);
    end
    for (int s = 0; s < 60; s++) begin
      b = (12*NP)'($urandom);
      step(1'b0, {((s % 6) < 3), ((s % 6) < 3)}, b, '0);
      tests_run++;
      if (p !== ref_p() || mode3 !== 2'b10) begin
        fails++; $display("FAIL mode3_run s=%0d got=%h/%b exp=%h/10", s, p, mode3, ref_p());
      end
      e1 = p7_r[1] ? {b[12], b[13], b[14], b[15], b[17], b[18]}
                   : {b[12], b[13], 2'b00, b[16], b[19]};
      tests_run++;
      if (p[11:6] !== e1) begin
        fails++; $display("FAIL mode3_ch1 s=%0d got=%b exp=%b", s, p[11:6], e1);
      end
    end
  endtask

  task automatic test_random();
    logic [NP-1:0] s;
    logic          r;
    s = '0;
    do_reset((12*NP)'($urandom));
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) if ($urandom_range(0, 7) == 0) s[i] = ~s[i];
      r = ($urandom_range(0, 99) == 0);
      step(r, s, (12*NP)'($urandom), NP'($urandom));
      tests_run++;
      if (p !== ref_p() || mode3 !== ref_mode3()) begin
        fails++; $display("FAIL random c=%0d got=%h/%b exp=%h/%b", c, p, mode3, ref_p(),
                          ref_mode3());
      end
    end
  endtask

`ifdef SMD_AUTOFIRE_EN
  task automatic test_autofire();
    logic [12*NP-1:0] b;
    logic             hist [$];
    b = '1;
    b[4]  = 1'b0;  // channel 0 a pressed
    b[17] = 1'b0;  // channel 1 b pressed
    do_reset(b);
    step(1'b0, 2'b10, b, 2'b01);
    for (int s = 0; s < 24; s++) begin
      step(1'b0, 2'b10, b, 2'b01);
      tests_run++;
      if (p !== ref_p()) begin
        fails++; $display("FAIL autofire s=%0d got=%h exp=%h", s, p, ref_p());
      end
      if (s >= 4) begin
        tests_run++;
        if (p[1] !== ~hist[s - 4]) begin
          fails++; $display("FAIL autofire_toggle s=%0d got=%b exp=%b", s, p[1], ~hist[s - 4]);
        end
      end
      hist.push_back(p[1]);
      tests_run++;
      if (p[7] !== 1'b0) begin
        fails++; $display("FAIL autofire_b_ch1 s=%0d got=%b exp=0", s, p[7]);
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst_r = 1'b1; p7_r = '0; btn_r = '1; turbo_r = '0;
    test_reset();
    test_six_button();
    test_timeout();
    test_coincident();
    test_mode3();
    test_random();
`ifdef SMD_AUTOFIRE_EN
    test_autofire();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
